// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
    case (f3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  // master: core plus memory model; slave: the load/store unit
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and byte/half merge for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = wdata;
    case (funct3)
      F3_B: begin
        load_val = {{24{byte_sel[7]}}, byte_sel};
        merged   = word;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      F3_BU: load_val = {24'h0, byte_sel};
      F3_H: begin
        load_val = {{16{half_sel[15]}}, half_sel};
        merged   = word;
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      F3_HU: load_val = {16'h0, half_sel};
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed requests to word memory, sub-word stores as RMW.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_WORDS_LOG2 = 17
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);
  state_t                state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_err;
  logic [DATA_WIDTH-1:0] align_word, load_val, merged;

  assign req_err = !f3_legal(bus.req_store, bus.req_funct3)
                 || misaligned(bus.req_funct3, bus.req_addr[1:0])
                 || (|bus.req_addr[DATA_WIDTH-1:MEM_WORDS_LOG2+2]);

  // Loads align live memory data; stores merge into the captured word.
  assign align_word = (state_q == LOAD) ? bus.mem_rd : merge_q;

  lsu_lane_align u_lane_align (
    .word     (align_word),
    .offset   (addr_q[1:0]),
    .funct3   (f3_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d = bus.req_store;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                        state_d = RESP;
          else if (!bus.req_store)            state_d = LOAD;
          else if (bus.req_funct3 == F3_W)    state_d = WRITE;
          else                                state_d = READ;
        end
      end
      LOAD: begin
        rdata_d = load_val;
        state_d = RESP;
      end
      READ: begin
        merge_d = bus.mem_rd;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = {2'b00, addr_q[DATA_WIDTH-1:2]};
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.mem_wd     = merged;

  // Only needed to document the latched direction; decode uses f3_q and state.
  logic unused_store;
  assign unused_store = store_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a small word-memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(32)) bus ();

  load_store_unit #(.DATA_WIDTH(32), .MEM_WORDS_LOG2(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 64-word memory; legal high indices alias onto it, which is harmless here.
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_wd = '0;

  assign bus.mem_rd = mem[bus.mem_addr[5:0]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wd;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.mem_addr;
      wr_wd   <= bus.mem_wd;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    int          lat;
    int          start;
    logic [5:0]  idx;

    vecs[0]  = '{1'b0, F3_B,   32'h11, 32'h0,        32'h8899AABB, 32'hFFFFFFAA, 1'b0, 2, 0, 32'h8899AABB};
    vecs[1]  = '{1'b0, F3_HU,  32'h12, 32'h0,        32'h8899AABB, 32'h00008899, 1'b0, 2, 0, 32'h8899AABB};
    vecs[2]  = '{1'b0, F3_H,   32'h12, 32'h0,        32'h8899AABB, 32'hFFFF8899, 1'b0, 2, 0, 32'h8899AABB};
    vecs[3]  = '{1'b0, F3_W,   32'h10, 32'h0,        32'h8899AABB, 32'h8899AABB, 1'b0, 2, 0, 32'h8899AABB};
    vecs[4]  = '{1'b0, F3_BU,  32'h13, 32'h0,        32'h8899AABB, 32'h00000088, 1'b0, 2, 0, 32'h8899AABB};
    vecs[5]  = '{1'b0, F3_H,   32'h10, 32'h0,        32'h8899AABB, 32'hFFFFAABB, 1'b0, 2, 0, 32'h8899AABB};
    vecs[6]  = '{1'b1, F3_B,   32'h12, 32'h123456CC, 32'h8899AABB, 32'h0,        1'b0, 3, 1, 32'h88CCAABB};
    vecs[7]  = '{1'b1, F3_H,   32'h12, 32'h0000BEEF, 32'h8899AABB, 32'h0,        1'b0, 3, 1, 32'hBEEFAABB};
    vecs[8]  = '{1'b1, F3_W,   32'h10, 32'hDEADBEEF, 32'h8899AABB, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, F3_W,   32'h13, 32'hDEADBEEF, 32'h8899AABB, 32'h0,        1'b1, 1, 0, 32'h8899AABB};
    vecs[10] = '{1'b0, F3_H,   32'h01, 32'h0,        32'h01020304, 32'h0,        1'b1, 1, 0, 32'h01020304};
    vecs[11] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h8899AABB, 32'h0,        1'b1, 1, 0, 32'h8899AABB};
    vecs[12] = '{1'b0, F3_W,   32'h00080000, 32'h0,  32'h55AA55AA, 32'h0,        1'b1, 1, 0, 32'h55AA55AA};
    vecs[13] = '{1'b0, F3_W,   32'h0007FFFC, 32'h0,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2, 0, 32'hCAFEF00D};
    vecs[14] = '{1'b1, F3_BU,  32'h10, 32'h000000FF, 32'h8899AABB, 32'h0,        1'b1, 1, 0, 32'h8899AABB};
    vecs[15] = '{1'b1, F3_B,   32'h13, 32'h000000FF, 32'h8899AABB, 32'h0,        1'b0, 3, 1, 32'hFF99AABB};

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      v   = vecs[i];
      idx = v.addr[7:2];
      preload(idx, v.init);
      start = wr_cnt;
      @(negedge clk);
      check($sformatf("v%0d_ready", i), {31'b0, bus.req_ready}, 32'h1);
      bus.req_valid  = 1'b1;
      bus.req_store  = v.store;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hFFFFFFFF;
      bus.req_wdata = 32'hA5A5A5A5;
      lat = 1;
      while (!bus.resp_valid && lat < 8) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("v%0d_resp_valid", i), {31'b0, bus.resp_valid}, 32'h1);
      check($sformatf("v%0d_latency", i), lat, v.exp_lat);
      check($sformatf("v%0d_err", i), {31'b0, bus.resp_err}, {31'b0, v.exp_err});
      check($sformatf("v%0d_rdata", i), bus.resp_rdata, v.exp_rdata);
      check($sformatf("v%0d_ready_in_resp", i), {31'b0, bus.req_ready}, 32'h0);
      check($sformatf("v%0d_writes", i), wr_cnt - start, v.exp_wr);
      if (v.exp_wr != 0) begin
        check($sformatf("v%0d_wr_addr", i), wr_addr, {2'b00, v.addr[31:2]});
        check($sformatf("v%0d_wr_wd", i), wr_wd, v.exp_mem);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pulse_one", i), {31'b0, bus.resp_valid}, 32'h0);
      check($sformatf("v%0d_rdata_hold", i), bus.resp_rdata, v.exp_rdata);
      check($sformatf("v%0d_err_hold", i), {31'b0, bus.resp_err}, {31'b0, v.exp_err});
      check($sformatf("v%0d_mem", i), mem[idx], v.exp_mem);
    end

    // Back-to-back: valid held high, second request waits for RESP to finish
    preload(6'd8, 32'h0);
    start = wr_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h01234567;
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h23;
    bus.req_wdata = 32'h76543210;
    check("b2b_first_busy", {31'b0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_first_resp", {31'b0, bus.resp_valid}, 32'h1);
    check("b2b_first_err", {31'b0, bus.resp_err}, 32'h0);
    check("b2b_ready_in_resp", {31'b0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_idle_ready", {31'b0, bus.req_ready}, 32'h1);
    check("b2b_idle_no_resp", {31'b0, bus.resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("b2b_second_resp", {31'b0, bus.resp_valid}, 32'h1);
    check("b2b_second_err", {31'b0, bus.resp_err}, 32'h1);
    check("b2b_second_rdata", bus.resp_rdata, 32'h0);
    check("b2b_writes", wr_cnt - start, 32'd1);
    check("b2b_mem", mem[8], 32'h01234567);

    // Reset during the READ state of an SH
    preload(6'd5, 32'h11223344);
    start = wr_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 32'h14;
    bus.req_wdata  = 32'h0000BEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rmw_rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check("rmw_rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmw_rst_ready", {31'b0, bus.req_ready}, 32'h1);
    check("rmw_rst_err", {31'b0, bus.resp_err}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rmw_post_resp_%0d", c), {31'b0, bus.resp_valid}, 32'h0);
    end
    check("rmw_no_write", wr_cnt - start, 32'd0);
    check("rmw_mem", mem[5], 32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: sits between the core's execute/memory stage and the word-indexed data memory (combinational read, write on posedge when write-enable is high).
- Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word stores run as read-modify-write.
- Uses a valid/ready request handshake and a one-cycle response pulse so the core can stall on it.

Parameters:
- DATA_WIDTH, 32, data and address width; fixed at 32 for RV32.
- MEM_WORDS_LOG2, 17, log2 of memory depth in words. Word indices at or above 2**MEM_WORDS_LOG2 are out of range.

Ports:
- clk  in  1  clock; everything is sampled on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; accept = req_valid && req_ready.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; only the low byte/half is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal-funct3 request; valid with resp_valid.
- mem_addr  out  DATA_WIDTH  word index, equal to the latched address >> 2, zero-extended.
- mem_we  out  1  memory write enable.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  combinational memory read data.

Behaviour:
- Reset values: state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, all latched request registers = 0.
  - req_ready = 1 once reset is released.
  - mem_we falls immediately on rst assertion, because it is decoded from state.
- States: IDLE, LOAD, READ, WRITE, RESP. req_ready, mem_we and mem_addr are decoded combinationally from state and the latched registers.
- IDLE, on accept:
  - Latch store flag, funct3, address and wdata.
  - Error check, in this order: illegal funct3 (loads allow {000, 001, 010, 100, 101}; stores allow {000, 001, 010}); then misalignment (half with addr[0] = 1; word with addr[1:0] != 0); then out of range (addr >> 2 >= 2**MEM_WORDS_LOG2).
  - On any error, go to RESP with err = 1. No memory write happens.
  - Otherwise: load goes to LOAD; SW goes to WRITE; SB/SH goes to READ.
- LOAD:
  - Select the lane from mem_rd, little-endian: the byte at addr[1:0], the half at addr[1].
  - Extend: sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through.
  - Register the result into resp_rdata, then go to RESP.
- READ: capture mem_rd into the merge register, then go to WRITE.
- WRITE:
  - mem_we = 1 for exactly one cycle.
  - mem_wd = req_wdata for SW. For SB/SH it is the merge register with the addressed byte/half replaced by the low byte/half of wdata.
  - Then go to RESP.
- RESP: resp_valid = 1 for one cycle, then go to IDLE.
  - req_ready is 0 during RESP, so a new request is accepted one cycle after the pulse at the earliest.
- Latency from accept edge to resp_valid:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- resp_rdata and resp_err hold their values until the next accept, where they clear to 0.
- req_* inputs are ignored while not in IDLE; latched values are used throughout.
- Reset mid-operation (any state): return to IDLE. A pending RMW is abandoned with no partial write. No response is issued.
- A byte address at the top of the range (word index 2**MEM_WORDS_LOG2 - 1) is legal; the next word index is out of range.

Decomposition:
- Package lsu_pkg:
  - state_t enum {IDLE, LOAD, READ, WRITE, RESP}.
  - funct3 localparams F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
- One sub-module, lsu_lane_align: purely combinational load extract/extend and store merge. Inputs: word, byte offset, funct3, wdata. Outputs: load value, merged word.

Test Plan:
- Word at index 4 = 0x8899AABB; LB at 0x11 -> resp_rdata = 0xFFFFFFAA, 2-cycle latency, mem_we never high.
- Same word; LHU at 0x12 -> resp_rdata = 0x00008899. LH at 0x12 -> 0xFFFF8899. LW at 0x10 -> 0x8899AABB.
- Word at index 4 = 0x8899AABB; SB 0x12 with wdata 0x123456CC -> mem_we high in exactly one cycle with mem_addr = 4 and mem_wd = 0x88CCAABB; resp_valid 3 cycles after accept.
- SW at 0x13 -> resp_err = 1 one cycle after accept, memory unchanged. LH at 0x01 -> err. Load funct3 = 3'b011 -> err. LW at 4·2**17 -> err.
- Back-to-back: req_valid held high with two SWs -> the second is accepted only after RESP, and each response carries its own err/rdata.
- Assert rst during the READ state of an SH -> mem_we never pulses, resp_valid stays 0, req_ready = 1 after release, memory unchanged.
